if_id_queue: RTL
================

IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; legal values are powers of two, 2 to 16.
REQ-002 The block SHALL have parameter NOP, default 32'h00000000, giving the instruction word presented when the queue is empty.
REQ-003 clk  in  1  clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ins_i  in  32  instruction word from the fetch stage.
REQ-006 pc4_i  in  32  PC+4 of ins_i from the fetch stage.
REQ-007 in_valid  in  1  fetch stage offers ins_i/pc4_i this cycle.
REQ-008 in_ready  out  1  queue can accept an entry; drives the fetch-stage PC enable.
REQ-009 flush  in  1  discard all queued entries (branch/jump redirect).
REQ-010 out_valid  out  1  the head entry is valid.
REQ-011 out_ready  in  1  decode stage consumes the head entry this cycle (deasserted on decode stall).
REQ-012 ins_o  out  32  head instruction word.
REQ-013 pc4_o  out  32  head PC+4.
REQ-014 count  out  log2(DEPTH)+1  number of occupied entries.

Function
REQ-015 The block SHALL be a FIFO with read pointer and write pointer, each log2(DEPTH) bits wide and wrapping modulo DEPTH, plus an occupancy counter.
REQ-016 A push SHALL occur when in_valid && in_ready && !flush, writing {ins_i, pc4_i} at the write pointer and incrementing that pointer.
REQ-017 A pop SHALL occur when out_valid && out_ready && !flush, incrementing the read pointer.
REQ-018 in_ready SHALL equal (count != DEPTH), derived only from registered state and never from out_ready.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 ins_o/pc4_o SHALL show the head entry when out_valid=1; otherwise ins_o=NOP and pc4_o=0.
REQ-021 Latency SHALL be one cycle: an entry pushed at edge N is visible at the output after edge N, with no combinational bypass when empty.
REQ-022 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-023 When full, in_ready=0, so a pop in the same cycle SHALL NOT admit a push; in_ready rises the cycle after the pop.
REQ-024 When empty, out_ready SHALL be ignored and count SHALL NOT underflow.
REQ-025 flush SHALL take priority over push and pop: at the next edge both pointers and count go to 0, and any push or pop offered in the flush cycle is dropped.
REQ-026 Storage contents SHALL NOT be cleared by flush or reset; only the pointers and count are cleared.
REQ-027 Entry order SHALL be preserved exactly (FIFO), including across pointer wrap-around.

Reset
REQ-028 While rst=1 at a clock edge, pointers and count SHALL become 0, giving out_valid=0, in_ready=1, ins_o=NOP and pc4_o=0.
REQ-029 rst SHALL take priority over flush, push and pop, including a reset asserted mid-stream with the queue partly full.

Structure
REQ-030 The shared CPU package SHALL hold the NOP constant, the default DEPTH, and the width function for log2(DEPTH).
REQ-031 Storage SHALL be a sub-module ifq_mem: DEPTH x 64-bit register array, one synchronous write port, and one combinational read port addressed by the read pointer.
REQ-032 Pointer, count and handshake logic SHALL reside in if_id_queue.

Verification
REQ-033 After reset, push 0x24010001/0x3004 with out_ready=0 -> after 1 edge out_valid=1, ins_o=0x24010001, pc4_o=0x3004, count=1.
REQ-034 Push 4 entries with out_ready=0 -> count=4, in_ready=0; a 5th offer is not accepted; pop 1 -> in_ready=1 on the following cycle.
REQ-035 With in_valid=1 and out_ready=1 held for 10 cycles, pushing pc4 0x3004..0x3028 -> outputs appear in order with no gap or duplicate; count stays 1; pointers wrap.
REQ-036 Fill to count=3, then assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, ins_o=0; the offered entry is absent.
REQ-037 Fill to count=2, then assert rst with flush, push and pop all active -> count=0, in_ready=1; a following push of 0x08000C00 emerges first.
REQ-038 Empty queue with out_ready=1 for 3 cycles -> count stays 0 and ins_o stays NOP.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared CPU constants (NOP word, default queue depth) and pointer-width helper
package if_id_queue_pkg;
  localparam int IFQ_DEPTH = 4;
  localparam logic [31:0] IFQ_NOP = 32'h00000000;
  function automatic int ptr_w(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction
endpackage

// File: rtl/if_id_queue_mem.sv
// ifq_mem: DEPTH x 64 storage, sync write (we/waddr/wdata), comb read (raddr/rdata), never cleared
module ifq_mem #(
  parameter int DEPTH = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [63:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID instruction FIFO; fetch side ins_i/pc4_i/in_valid/in_ready, decode side ins_o/pc4_o/out_valid/out_ready, flush, count
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter logic [31:0] NOP = IFQ_NOP
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            ins_i,
  input  logic [31:0]            pc4_i,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            ins_o,
  output logic [31:0]            pc4_o,
  output logic [ptr_w(DEPTH):0]  count
);
  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wp, rp;
  logic [63:0] rdata;
  logic push, pop;
  assign in_ready = count != FULL;
  assign out_valid = count != '0;
  assign push = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready && !flush;
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  ifq_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk(clk),
    .we(push),
    .waddr(wp),
    .wdata({ins_i, pc4_i}),
    .raddr(rp),
    .rdata(rdata)
  );
  assign ins_o = out_valid ? rdata[63:32] : NOP;
  assign pc4_o = out_valid ? rdata[31:0] : 32'h0;
endmodule
